cascade_timer_ctrl: RTL and testbench
=====================================

# cascade_timer_ctrl

Sequencing controller that turns two cascaded 4-bit synchronous parallel-load up-counters (low and high nibble, each with load, cnt_en, async clear and carry = all-ones) into an 8-bit programmable interval timer. It accepts a period/mode configuration through a valid/ready handshake, preloads the counter pair, and gates counting with a pause input. It detects terminal count from the two carries and produces one-shot or auto-reload expiry pulses. It sits between the control/register logic and the counter datapath and is the only driver of the counters' control inputs.

## Interface
- No parameters; counter width is fixed at 2 x 4 bits.
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  controller can accept a configuration; high only in IDLE.
- cfg_period  in  8  period P in cycles; 0 encodes 256.
- cfg_mode  in  1  0 = one-shot, 1 = auto-reload.
- pause  in  1  level; freezes counting while high in RUN.
- abort  in  1  single-cycle request; stops the timer and clears the counters.
- carry_lo, carry_hi  in  1 each  carries from the low and high counters.
- cnt_load  out  1  load strobe to both counters.
- ld_val  out  8  preload value; [3:0] drives the low counter's I, [7:4] drives the high counter's I.
- cnt_en_lo, cnt_en_hi  out  1 each  count enables.
- cnt_clrn  out  1  registered active-low clear to both counters.
- busy  out  1  high in LOAD or RUN.
- expire  out  1  one-cycle pulse at terminal count.

## Operation
- States: IDLE, LOAD, RUN. Internal registers: preload L (8 bits) and mode (1 bit).
- IDLE: cfg_ready = 1. On cfg_valid, register L = (-cfg_period) mod 256 and mode, then go to LOAD. With P = 0, L = 0x00 (256 cycles).
- LOAD: one cycle. cnt_load = 1 and ld_val = L. Go to RUN.
- RUN, pause = 0:
  - cnt_en_lo = 1.
  - cnt_en_hi = carry_lo, a combinational ripple enable.
  - Terminal (tc) = carry_lo & carry_hi, i.e. count = 0xFF.
- RUN with tc:
  - Assert expire.
  - One-shot: drive cnt_en_lo = cnt_en_hi = 0, so the count holds at 0xFF, and go to IDLE.
  - Auto-reload: cnt_load = 1 with ld_val = L and stay in RUN. Load has priority over enable in the counters.
- RUN, pause = 1: both enables 0, cnt_load = 0, tc ignored, expire = 0. If count is 0xFF when pause falls, expire occurs on the first unpaused cycle.
- abort, in any state and highest priority: go to IDLE.
  - cnt_clrn is registered low for exactly one cycle, the cycle after abort is sampled.
  - expire is suppressed in the abort cycle.
  - cnt_load and both enables are 0 in the abort cycle.
- ld_val = L at all times; it is only meaningful while cnt_load = 1.
- cfg_valid is ignored while busy; there is no queuing.
- Outputs cnt_load, cnt_en_*, expire, cfg_ready and busy are combinational from state, pause, abort and the carries. cnt_clrn and state come from flops.

## Timing
- Reset (rstn low):
  - state = IDLE, L = 0x00, mode = 0.
  - cnt_clrn = 0, holding the counters clear.
  - cfg_ready = 1, busy = 0, expire = 0, cnt_load = 0, both enables = 0.
- cnt_clrn rises on the first clk edge after rstn deasserts.
- Handshake: the transfer occurs on the edge where cfg_valid & cfg_ready. The LOAD cycle follows immediately.
- Latency: the first expire is P + 1 cycles after the accept edge, counting 1 LOAD cycle plus P RUN cycles with the terminal in the P-th cycle.
- Auto-reload: expire repeats every P cycles exactly while pause = 0. Each pause-high cycle lengthens the current period by 1.
- P = 1: L = 0xFF, tc in the first RUN cycle. Auto-reload gives expire every cycle.
- Abort in LOAD: the load is cancelled and the counters are cleared next cycle.
- Simultaneous abort and tc: abort wins; there is no expire.
- Simultaneous cfg_valid and abort in IDLE: abort wins; the configuration is not accepted.
- Reset mid-RUN: return immediately to the reset values; no expire.

## Test plan
- Reset, then cfg P = 5, one-shot: ready drops, LOAD loads 0xFB, expire pulses once 6 cycles after accept, counter holds 0xFF, and the controller returns to IDLE with cfg_ready = 1.
- cfg P = 3, auto-reload, 20 cycles: expire at accept + 4, + 7, + 10, and so on. ld_val = 0xFD is reloaded at each expire.
- cfg P = 0, one-shot: L = 0x00. cnt_en_hi asserts only when the low nibble = 0xF. Expire occurs at accept + 257.
- cfg P = 4, auto-reload, with pause high for 3 cycles mid-period: that period stretches to 7 cycles, and the next period is back to 4.
- Abort during RUN, and abort coinciding with tc: cnt_clrn is low for 1 cycle, no expire, IDLE follows, and cfg_valid in the abort cycle is ignored.
- cfg_valid asserted while busy: no accept, and mode and L are unchanged. Also cover P = 1 auto-reload, where expire is high every cycle after LOAD.

Source files
------------

// File: rtl/cascade_timer_ctrl.sv
// Sequencing controller for a pair of cascaded 4-bit load/enable counters.
// It takes a period and mode over a valid/ready handshake, preloads the
// counters with -P, gates counting with pause, and flags terminal count
// (0xFF) as a one-shot or auto-reload expiry pulse.
module cascade_timer_ctrl (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_period,
  input  logic       cfg_mode,
  input  logic       pause,
  input  logic       abort,
  input  logic       carry_lo,
  input  logic       carry_hi,
  output logic       cnt_load,
  output logic [7:0] ld_val,
  output logic       cnt_en_lo,
  output logic       cnt_en_hi,
  output logic       cnt_clrn,
  output logic       busy,
  output logic       expire
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e     state_q, state_d;
  logic [7:0] preload_q, preload_d;
  logic       mode_q, mode_d;
  logic       cnt_clrn_q, cnt_clrn_d;
  logic       tc;

  assign tc       = carry_lo & carry_hi;
  assign ld_val   = preload_q;
  assign cnt_clrn = cnt_clrn_q;

  // State and configuration registers; the clear strobe is held low through reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      preload_q  <= 8'h00;
      mode_q     <= 1'b0;
      cnt_clrn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      preload_q  <= preload_d;
      mode_q     <= mode_d;
      cnt_clrn_q <= cnt_clrn_d;
    end
  end

  // Next-state and counter control; abort overrides everything at the end.
  always_comb begin
    state_d    = state_q;
    preload_d  = preload_q;
    mode_d     = mode_q;
    cnt_clrn_d = ~abort;
    cfg_ready  = 1'b0;
    cnt_load   = 1'b0;
    cnt_en_lo  = 1'b0;
    cnt_en_hi  = 1'b0;
    expire     = 1'b0;
    busy       = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          // Counting up from -P reaches 0xFF after P cycles; P = 0 gives 256.
          preload_d = 8'h00 - cfg_period;
          mode_d    = cfg_mode;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        cnt_load = 1'b1;
        state_d  = StRun;
      end
      StRun: begin
        if (!pause) begin
          cnt_en_lo = 1'b1;
          // High nibble ripples on the low carry within the same cycle.
          cnt_en_hi = carry_lo;
          if (tc) begin
            expire = 1'b1;
            if (mode_q) begin
              // Load wins over enable inside the counters.
              cnt_load = 1'b1;
            end else begin
              cnt_en_lo = 1'b0;
              cnt_en_hi = 1'b0;
              state_d   = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d   = StIdle;
      preload_d = preload_q;
      mode_d    = mode_q;
      cnt_load  = 1'b0;
      cnt_en_lo = 1'b0;
      cnt_en_hi = 1'b0;
      expire    = 1'b0;
    end
  end

endmodule

// File: tb/tb_cascade_timer_ctrl.sv
// Directed bench for cascade_timer_ctrl with a behavioural model of the
// two cascaded 4-bit counters closing the carry loop.
module tb_cascade_timer_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_period;
  logic       cfg_mode;
  logic       pause;
  logic       abort;
  logic       carry_lo;
  logic       carry_hi;
  logic       cnt_load;
  logic [7:0] ld_val;
  logic       cnt_en_lo;
  logic       cnt_en_hi;
  logic       cnt_clrn;
  logic       busy;
  logic       expire;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cascade_timer_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_mode   (cfg_mode),
    .pause      (pause),
    .abort      (abort),
    .carry_lo   (carry_lo),
    .carry_hi   (carry_hi),
    .cnt_load   (cnt_load),
    .ld_val     (ld_val),
    .cnt_en_lo  (cnt_en_lo),
    .cnt_en_hi  (cnt_en_hi),
    .cnt_clrn   (cnt_clrn),
    .busy       (busy),
    .expire     (expire)
  );

  // Counter pair: async clear, load over enable, carry when all ones.
  logic [3:0] lo_q, hi_q;
  logic [7:0] count;
  assign count    = {hi_q, lo_q};
  assign carry_lo = &lo_q;
  assign carry_hi = &hi_q;

  always @(posedge clk or negedge cnt_clrn) begin
    if (!cnt_clrn) begin
      lo_q <= 4'h0;
      hi_q <= 4'h0;
    end else if (cnt_load) begin
      lo_q <= ld_val[3:0];
      hi_q <= ld_val[7:4];
    end else begin
      if (cnt_en_lo) lo_q <= lo_q + 4'h1;
      if (cnt_en_hi) hi_q <= hi_q + 4'h1;
    end
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Handshake a config; returns sampling inside the LOAD cycle (cycle 1).
  task automatic accept(input logic [7:0] p, input logic m, input logic [7:0] exp_ld);
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_mode   = m;
    #1;
    check_eq("acc_ready", cfg_ready, 1'b1);
    tick;
    cfg_valid = 1'b0;
    #1;
    check_eq("load_strobe", {cnt_load, ld_val}, {1'b1, exp_ld});
    check_eq("load_busy", {busy, cfg_ready}, 2'b10);
  endtask

  // Step cycles until expire is seen; c is the cycle index since accept.
  task automatic wait_expire(input int start, input int limit, output int c);
    bit found;
    found = 1'b0;
    c = start;
    while (!found && c < limit) begin
      tick;
      #1;
      c++;
      if (expire) found = 1'b1;
    end
    if (!found) c = -1;
  endtask

  // Single-cycle abort from RUN, then check the clear pulse and IDLE.
  task automatic do_abort(input string tag);
    tick;
    abort = 1'b1;
    #1;
    check_eq({tag, "_outs"}, {expire, cnt_load, cnt_en_lo, cnt_en_hi}, 4'b0000);
    tick;
    abort = 1'b0;
    #1;
    check_eq({tag, "_clr"}, {cnt_clrn, cfg_ready, busy, count}, {3'b010, 8'h00});
    tick;
    #1;
    check_eq({tag, "_clr_rise"}, cnt_clrn, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int bad;
    int q[$];

    rstn = 1'b0; cfg_valid = 1'b0; cfg_period = 8'h00; cfg_mode = 1'b0;
    pause = 1'b0; abort = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outs", {cfg_ready, busy, expire, cnt_load, cnt_en_lo, cnt_en_hi, cnt_clrn},
             7'b1000000);
    check_eq("rst_ldval", ld_val, 8'h00);
    rstn = 1'b1;
    #1;
    check_eq("clrn_before_edge", cnt_clrn, 1'b0);
    tick;
    #1;
    check_eq("clrn_after_edge", cnt_clrn, 1'b1);

    // P = 5 one-shot: expire at accept + 6, hold 0xFF, back to IDLE.
    accept(8'd5, 1'b0, 8'hFB);
    wait_expire(1, 20, c);
    check_eq("p5_latency", 16'(c), 16'd6);
    check_eq("p5_tc_ctl", {cnt_load, cnt_en_lo, cnt_en_hi}, 3'b000);
    tick;
    #1;
    check_eq("p5_idle", {cfg_ready, busy, expire, count}, {3'b100, 8'hFF});
    tick;
    #1;
    check_eq("p5_hold", count, 8'hFF);

    // P = 3 auto-reload: expires at 4, 7, 10, ... with reload of 0xFD.
    accept(8'd3, 1'b1, 8'hFD);
    q.delete();
    for (int k = 2; k <= 20; k++) begin
      tick;
      #1;
      if (expire) begin
        q.push_back(k);
        check_eq("p3_reload", {cnt_load, ld_val}, 9'h1FD);
      end
    end
    check_eq("p3_count", 16'(q.size()), 16'd6);
    for (int i = 0; i < q.size() && i < 6; i++) check_eq("p3_when", 16'(q[i]), 16'(4 + 3 * i));
    do_abort("p3_abort");

    // Abort coinciding with terminal count, with cfg_valid in the same cycle.
    accept(8'd2, 1'b0, 8'hFE);
    tick;
    #1;
    tick;
    abort = 1'b1; cfg_valid = 1'b1; cfg_period = 8'h10; cfg_mode = 1'b1;
    #1;
    check_eq("abtc_at_ff", count, 8'hFF);
    check_eq("abtc_no_expire", {expire, cnt_load, cnt_en_lo}, 3'b000);
    tick;
    abort = 1'b0; cfg_valid = 1'b0;
    #1;
    check_eq("abtc_idle", {busy, cfg_ready, cnt_clrn}, 3'b010);
    // Abort together with cfg_valid in IDLE: configuration must be refused.
    abort = 1'b1; cfg_valid = 1'b1;
    tick;
    abort = 1'b0; cfg_valid = 1'b0;
    #1;
    check_eq("idle_abort_cfg", {busy, cfg_ready, ld_val}, {2'b01, 8'hFE});
    tick;
    #1;

    // P = 0 one-shot: 256-cycle period, high enable only on low nibble 0xF.
    accept(8'd0, 1'b0, 8'h00);
    bad = 0;
    c = 1;
    while (c < 300 && !expire) begin
      tick;
      #1;
      c++;
      if (!expire && (cnt_en_hi !== (lo_q == 4'hF))) bad++;
    end
    check_eq("p0_latency", 16'(c), 16'd257);
    check_eq("p0_en_hi", 16'(bad), 16'd0);
    tick;
    #1;

    // P = 4 auto-reload with pause high in cycles 10..12.
    accept(8'd4, 1'b1, 8'hFC);
    q.delete();
    bad = 0;
    for (int k = 2; k <= 21; k++) begin
      tick;
      pause = (k >= 10 && k <= 12);
      #1;
      if (pause && (cnt_en_lo || cnt_en_hi || cnt_load || expire)) bad++;
      if (expire) q.push_back(k);
    end
    pause = 1'b0;
    check_eq("pause_gating", 16'(bad), 16'd0);
    check_eq("pause_count", 16'(q.size()), 16'd4);
    if (q.size() == 4) begin
      check_eq("pause_e0", 16'(q[0]), 16'd5);
      check_eq("pause_e1", 16'(q[1]), 16'd9);
      check_eq("pause_e2", 16'(q[2]), 16'd16);
      check_eq("pause_e3", 16'(q[3]), 16'd20);
    end
    do_abort("pause_abort");

    // cfg_valid while busy is ignored; L and mode stay as configured.
    accept(8'd6, 1'b0, 8'hFA);
    tick;
    #1;
    tick;
    cfg_valid = 1'b1; cfg_period = 8'd1; cfg_mode = 1'b1;
    #1;
    check_eq("busy_ready", {busy, cfg_ready}, 2'b10);
    cfg_valid = 1'b0;
    wait_expire(3, 20, c);
    check_eq("busy_latency", 16'(c), 16'd7);
    tick;
    #1;
    check_eq("busy_oneshot", {busy, ld_val}, {1'b0, 8'hFA});

    // P = 1 auto-reload: expire every cycle after LOAD.
    accept(8'd1, 1'b1, 8'hFF);
    bad = 0;
    for (int k = 2; k <= 9; k++) begin
      tick;
      #1;
      if (expire === 1'b1 && cnt_load === 1'b1) bad++;
    end
    check_eq("p1_every_cycle", 16'(bad), 16'd8);
    do_abort("p1_abort");

    // Reset in the middle of RUN returns to reset values at once.
    accept(8'd5, 1'b1, 8'hFB);
    tick;
    #1;
    tick;
    rstn = 1'b0;
    #1;
    check_eq("midrst_outs", {expire, busy, cfg_ready, cnt_clrn, cnt_load, cnt_en_lo},
             6'b001000);
    check_eq("midrst_state", {ld_val, count}, 16'h0000);
    tick;
    rstn = 1'b1;
    tick;
    #1;
    check_eq("midrst_release", {cnt_clrn, cfg_ready}, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
